// File: rtl/game_ctl.sv
`default_nettype none
// ============================================================================
// Module      : game_ctl
// Description : Tic-tac-toe game controller in the pixel clock domain.
//               Converts mouse position and left-button edges into board
//               moves, alternates X/O turns and detects wins and draws.
// Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
// Ports
//   pclk        in   1   pixel clock
//   rst_n       in   1   asynchronous active-low reset
//   xpos, ypos  in   12  mouse coordinates (already synchronized)
//   left        in   1   mouse left button level (already synchronized)
//   restart     in   1   synchronous new-game request (level)
//   board       out  18  cell i at [2i+1:2i], i = 3*row+col; 00/01(X)/10(O)
//   turn        out  1   0 = X to move, 1 = O to move
//   game_over   out  1   high while the game is finished
//   winner      out  2   00 none/draw, 01 X, 10 O
//   win_line    out  4   0-2 rows, 3-5 cols, 6 main diag, 7 anti diag, F none
//   move_cnt    out  4   number of marks placed (0..9)
//   hover_cell  out  4   cell under the cursor, F when outside the board
// ============================================================================
module game_ctl #(
    parameter int BOARD_X   = 128,
    parameter int BOARD_Y   = 0,
    parameter int CELL_SIZE = 256
) (
    input  logic        pclk,
    input  logic        rst_n,
    input  logic [11:0] xpos,
    input  logic [11:0] ypos,
    input  logic        left,
    input  logic        restart,
    output logic [17:0] board,
    output logic        turn,
    output logic        game_over,
    output logic [1:0]  winner,
    output logic [3:0]  win_line,
    output logic [3:0]  move_cnt,
    output logic [3:0]  hover_cell
);

    // Grid edges, 13 bits wide so the additions cannot overflow.
    localparam logic [12:0] c_x0 = 13'(BOARD_X);
    localparam logic [12:0] c_x1 = 13'(BOARD_X + CELL_SIZE);
    localparam logic [12:0] c_x2 = 13'(BOARD_X + 2 * CELL_SIZE);
    localparam logic [12:0] c_x3 = 13'(BOARD_X + 3 * CELL_SIZE);
    localparam logic [12:0] c_y0 = 13'(BOARD_Y);
    localparam logic [12:0] c_y1 = 13'(BOARD_Y + CELL_SIZE);
    localparam logic [12:0] c_y2 = 13'(BOARD_Y + 2 * CELL_SIZE);
    localparam logic [12:0] c_y3 = 13'(BOARD_Y + 3 * CELL_SIZE);

    localparam logic [3:0] c_none = 4'hF;

    typedef enum logic [1:0] {
        S_WAIT  = 2'd0,
        S_PLACE = 2'd1,
        S_EVAL  = 2'd2,
        S_OVER  = 2'd3
    } state_t;

    state_t      state_q;
    logic        left_d_q;
    logic [17:0] board_q;
    logic        turn_q;
    logic        game_over_q;
    logic [1:0]  winner_q;
    logic [3:0]  win_line_q;
    logic [3:0]  move_cnt_q;
    logic [3:0]  hover_q;
    logic [3:0]  cell_q;
    logic        cell_vld_q;

    // ------------------------------------------------------------------
    // Cursor to cell mapping (comparators only)
    // ------------------------------------------------------------------
    function automatic logic in_span(input logic [12:0] v,
                                     input logic [12:0] lo,
                                     input logic [12:0] hi);
        return (v >= lo) && (v < hi);
    endfunction

    logic [12:0] x_w, y_w;
    logic [1:0]  col_w, row_w;
    logic        col_vld_w, row_vld_w;
    logic [3:0]  idx_w;
    logic        idx_vld_w;

    assign x_w = {1'b0, xpos};
    assign y_w = {1'b0, ypos};

    always_comb begin
        col_w     = 2'd0;
        col_vld_w = 1'b1;
        if (in_span(x_w, c_x0, c_x1))      col_w = 2'd0;
        else if (in_span(x_w, c_x1, c_x2)) col_w = 2'd1;
        else if (in_span(x_w, c_x2, c_x3)) col_w = 2'd2;
        else                               col_vld_w = 1'b0;
    end

    always_comb begin
        row_w     = 2'd0;
        row_vld_w = 1'b1;
        if (in_span(y_w, c_y0, c_y1))      row_w = 2'd0;
        else if (in_span(y_w, c_y1, c_y2)) row_w = 2'd1;
        else if (in_span(y_w, c_y2, c_y3)) row_w = 2'd2;
        else                               row_vld_w = 1'b0;
    end

    // 3*row + col without a multiplier: (row << 1) + row + col.
    assign idx_w     = {1'b0, row_w, 1'b0} + {2'b00, row_w} + {2'b00, col_w};
    assign idx_vld_w = col_vld_w & row_vld_w;

    // ------------------------------------------------------------------
    // Board decode and win detection
    // ------------------------------------------------------------------
    logic [1:0] cell_w [9];

    for (genvar gi = 0; gi < 9; gi++) begin : g_cells
        assign cell_w[gi] = board_q[2*gi+1:2*gi];
    end

    function automatic logic [1:0] line_mark(input logic [1:0] a,
                                             input logic [1:0] b,
                                             input logic [1:0] c);
        return ((a != 2'b00) && (a == b) && (b == c)) ? a : 2'b00;
    endfunction

    logic [1:0] line_w [8];
    logic       win_w;
    logic [3:0] win_idx_w;
    logic [1:0] win_mark_w;

    always_comb begin
        line_w[0] = line_mark(cell_w[0], cell_w[1], cell_w[2]);
        line_w[1] = line_mark(cell_w[3], cell_w[4], cell_w[5]);
        line_w[2] = line_mark(cell_w[6], cell_w[7], cell_w[8]);
        line_w[3] = line_mark(cell_w[0], cell_w[3], cell_w[6]);
        line_w[4] = line_mark(cell_w[1], cell_w[4], cell_w[7]);
        line_w[5] = line_mark(cell_w[2], cell_w[5], cell_w[8]);
        line_w[6] = line_mark(cell_w[0], cell_w[4], cell_w[8]);
        line_w[7] = line_mark(cell_w[2], cell_w[4], cell_w[6]);
    end

    // Scan from the highest line down so the lowest winning index is kept.
    always_comb begin
        win_w      = 1'b0;
        win_idx_w  = c_none;
        win_mark_w = 2'b00;
        for (int l = 7; l >= 0; l--) begin
            if (line_w[l] != 2'b00) begin
                win_w      = 1'b1;
                win_idx_w  = 4'(l);
                win_mark_w = line_w[l];
            end
        end
    end

    logic [1:0] target_w;
    logic [1:0] mark_w;
    logic       click_w;
    logic       write_w;

    always_comb begin
        target_w = 2'b00;
        for (int i = 0; i < 9; i++) begin
            if (cell_q == 4'(i)) target_w = cell_w[i];
        end
    end

    assign mark_w  = turn_q ? 2'b10 : 2'b01;
    assign click_w = left & ~left_d_q;
    assign write_w = (state_q == S_PLACE) && cell_vld_q && (target_w == 2'b00);

    // ------------------------------------------------------------------
    // Game FSM and all registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_WAIT;
            left_d_q    <= 1'b0;
            board_q     <= '0;
            turn_q      <= 1'b0;
            game_over_q <= 1'b0;
            winner_q    <= 2'b00;
            win_line_q  <= c_none;
            move_cnt_q  <= 4'd0;
            hover_q     <= c_none;
            cell_q      <= 4'd0;
            cell_vld_q  <= 1'b0;
        end else begin
            left_d_q <= left;
            hover_q  <= idx_vld_w ? idx_w : c_none;

            // restart and a click in OVER both start a fresh game;
            // restart wins over any click because this branch is first.
            if (restart || (state_q == S_OVER && click_w)) begin
                state_q     <= S_WAIT;
                board_q     <= '0;
                turn_q      <= 1'b0;
                game_over_q <= 1'b0;
                winner_q    <= 2'b00;
                win_line_q  <= c_none;
                move_cnt_q  <= 4'd0;
                cell_q      <= 4'd0;
                cell_vld_q  <= 1'b0;
            end else begin
                case (state_q)
                    S_WAIT: begin
                        if (click_w) begin
                            cell_q     <= idx_w;
                            cell_vld_q <= idx_vld_w;
                            state_q    <= S_PLACE;
                        end
                    end
                    S_PLACE: begin
                        if (write_w) begin
                            for (int i = 0; i < 9; i++) begin
                                if (cell_q == 4'(i)) board_q[2*i +: 2] <= mark_w;
                            end
                            if (move_cnt_q != 4'd9) move_cnt_q <= move_cnt_q + 4'd1;
                            state_q <= S_EVAL;
                        end else begin
                            state_q <= S_WAIT;
                        end
                    end
                    S_EVAL: begin
                        if (win_w) begin
                            winner_q    <= win_mark_w;
                            win_line_q  <= win_idx_w;
                            game_over_q <= 1'b1;
                            state_q     <= S_OVER;
                        end else if (move_cnt_q == 4'd9) begin
                            winner_q    <= 2'b00;
                            win_line_q  <= c_none;
                            game_over_q <= 1'b1;
                            state_q     <= S_OVER;
                        end else begin
                            turn_q  <= ~turn_q;
                            state_q <= S_WAIT;
                        end
                    end
                    default: begin
                        // S_OVER: board frozen until a click or restart.
                        state_q <= S_OVER;
                    end
                endcase
            end
        end
    end

`ifndef SYNTHESIS
    // A full board has no empty cell, so a tenth write cannot happen.
    a_no_tenth_move: assert property (@(posedge pclk) disable iff (!rst_n)
        !(write_w && !restart && move_cnt_q == 4'd9));
`endif

    assign board      = board_q;
    assign turn       = turn_q;
    assign game_over  = game_over_q;
    assign winner     = winner_q;
    assign win_line   = win_line_q;
    assign move_cnt   = move_cnt_q;
    assign hover_cell = hover_q;

endmodule
`default_nettype wire

// File: doc/game_ctl.md
Name: game_ctl

Overview:
Central tic-tac-toe game controller. It turns synchronized mouse position and left-button events into board moves, alternates X/O turns, and detects wins and draws. It exposes the registered board state and game status for the drawing pipeline to render. It sits in the 75 MHz pixel domain, fed by the double-synchronized mouse coordinates and button.

Parameters:
BOARD_X, 128, x pixel of the board's left edge
BOARD_Y, 0, y pixel of the board's top edge
CELL_SIZE, 256, cell edge in pixels (square cells, 3x3 grid)

Ports:
pclk  input  1  pixel clock (75 MHz)
rst_n  input  1  reset, asynchronous, active-low
xpos  input  12  mouse x, already synchronized to pclk
ypos  input  12  mouse y, already synchronized to pclk
left  input  1  mouse left button level, already synchronized
restart  input  1  synchronous new-game request, level
board  output  18  cell i at bits [2i+1:2i]; i = 3*row+col; 00 empty, 01 X, 10 O
turn  output  1  0 = X to move, 1 = O to move
game_over  output  1  high in OVER state
winner  output  2  00 none/draw, 01 X, 10 O
win_line  output  4  0-2 rows, 3-5 cols, 6 main diag (0,4,8), 7 anti diag (2,4,6), 4'hF none
move_cnt  output  4  moves placed, 0..9
hover_cell  output  4  cell under cursor, 4'hF when outside board

Behaviour:
- Reset (rst_n low, async): board=0, turn=0, game_over=0, winner=00, win_line=4'hF, move_cnt=0, hover_cell=4'hF, state=WAIT, left_d=0. All outputs are registered.
- Click detect: left_d <= left every cycle; click = left & ~left_d (one-cycle pulse). Held button gives exactly one click.
- Cell mapping uses comparators only, no divider. col c when BOARD_X+c*CELL_SIZE <= xpos < BOARD_X+(c+1)*CELL_SIZE. Rows map the same way on ypos. Outside any of these ranges = invalid. Widen to 13 bits before the add so there is no overflow.
- hover_cell updates every cycle (1-cycle latency) from xpos/ypos, in every state.
- FSM states WAIT, PLACE, EVAL, OVER:
  - WAIT: on click, latch cell index and valid flag, then go to PLACE.
  - PLACE: if valid and the cell is 00, write 01 (turn=0) or 10 (turn=1), move_cnt+1, go to EVAL. Otherwise return to WAIT with no change, turn unchanged.
  - EVAL: check the 8 lines on the updated board, lowest line index first.
    - Win: winner = mark, win_line = index, game_over=1, go to OVER.
    - Else if move_cnt==9: draw, winner=00, win_line=4'hF, game_over=1, go to OVER.
    - Else: toggle turn, go to WAIT.
  - OVER: board frozen. A click goes to WAIT with all game state cleared to reset values.
- Latency: a click detected in cycle N updates board at the N+2 edge; turn, game_over and winner update at the N+3 edge.
- Clicks arriving in PLACE or EVAL are ignored (not queued).
- restart high in any state: next edge clears all state to reset values and enters WAIT. restart takes priority over a simultaneous click.
- move_cnt saturates at 9. A 10th write is impossible by construction and is asserted in simulation.

Test Plan:
- Reset, then click at (200,100) -> board=18'h00001, move_cnt=1, turn=1 three cycles after the click pulse.
- Click again at (200,100) after the first move -> board unchanged, turn stays 1, move_cnt=1.
- Click at (100,100) (x < 128) and at (500,800) (y > 767) -> no change; hover_cell=4'hF for both.
- Alternate moves X0, O3, X1, O4, X2 -> game_over=1, winner=01, win_line=0, board=18'h00295. A further click clears all state to reset values.
- Draw sequence X0,O1,X2,O4,X3,O5,X7,O6,X8 -> game_over=1, winner=00, win_line=4'hF, move_cnt=9.
- Hold left high for 1000 cycles over an empty cell -> exactly one move. restart asserted mid-game -> board=0, turn=0 on the next cycle. rst_n pulled low asynchronously mid-EVAL -> all outputs at reset values immediately.
